// File: rtl/nios2_oci_pkg.sv
// nios2_oci_pkg: FSM states, JTAG command codes and jdo field offsets
// shared by the OCI debug memory controller.
package nios2_oci_pkg;
    typedef enum logic [2:0] {S_IDLE, S_JWR, S_JRD, S_JRD_W, S_CWR, S_CRD, S_CRD_W} state_e;
    typedef enum logic [1:0] {CMD_ADDR, CMD_WR, CMD_RD} cmd_e;
    localparam int JDO_ADDR_LSB  = 17;
    localparam int JDO_WDATA_LSB = 3;
endpackage

// File: rtl/nios2_oci_cmd_slot.sv
// nios2_oci_cmd_slot: one-deep JTAG command holder; exposes the pending command
// (held or arriving this cycle) so the sequencer can start without a bubble.
module nios2_oci_cmd_slot
    import nios2_oci_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        take_action_ocimem_a,
    input  logic        take_action_ocimem_b,
    input  logic        take_no_action_ocimem_a,
    input  logic [37:0] jdo,
    input  logic        clr,
    output logic        slot_valid,
    output logic [31:0] slot_payload,
    output logic        pend_valid,
    output cmd_e        pend_cmd,
    output logic [31:0] pend_payload,
    output logic        overflow
);
    logic        valid_q, valid_d;
    cmd_e        cmd_q, cmd_d, stb_cmd;
    logic [31:0] payload_q, payload_d;
    logic        any_stb, multi_stb, accept;
    logic        unused_jdo;

    assign unused_jdo = ^{jdo[37:JDO_WDATA_LSB+32], jdo[JDO_WDATA_LSB-1:0]};

    always_comb begin
        any_stb      = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
        multi_stb    = (take_action_ocimem_a & take_action_ocimem_b) |
                       (take_action_ocimem_a & take_no_action_ocimem_a) |
                       (take_action_ocimem_b & take_no_action_ocimem_a);
        stb_cmd      = take_action_ocimem_a ? CMD_ADDR : take_action_ocimem_b ? CMD_WR : CMD_RD;
        accept       = any_stb & !valid_q;
        overflow     = (any_stb & valid_q) | multi_stb;
        pend_valid   = valid_q | accept;
        pend_cmd     = valid_q ? cmd_q : stb_cmd;
        pend_payload = valid_q ? payload_q : jdo[JDO_WDATA_LSB +: 32];
        valid_d      = clr ? 1'b0 : pend_valid;
        cmd_d        = accept ? stb_cmd : cmd_q;
        payload_d    = accept ? jdo[JDO_WDATA_LSB +: 32] : payload_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q   <= 1'b0;
            cmd_q     <= CMD_ADDR;
            payload_q <= '0;
        end else begin
            valid_q   <= valid_d;
            cmd_q     <= cmd_d;
            payload_q <= payload_d;
        end
    end

    assign slot_valid   = valid_q;
    assign slot_payload = payload_q;
endmodule

// File: rtl/nios2_oci_debug_mem_ctrl.sv
// nios2_oci_debug_mem_ctrl: sequences JTAG debug-RAM commands and, when
// NIOS2_OCIMEM_CPU_PORT_EN is defined, round-robins the RAM with a CPU Avalon slave.
module nios2_oci_debug_mem_ctrl
    import nios2_oci_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic [37:0]       jdo,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [DATA_W-1:0] cpu_writedata,
    output logic [DATA_W-1:0] cpu_readdata,
    output logic              cpu_waitrequest,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);
    localparam int ADDR_OFS = JDO_ADDR_LSB - JDO_WDATA_LSB;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] jaddr_q, jaddr_d;
    logic [DATA_W-1:0] mon_dreg_q, mon_dreg_d, cpu_rdata_q, cpu_rdata_d;
    logic              last_jtag_q, last_jtag_d, error_q, error_d;
    logic              slot_valid, pend_valid, overflow, slot_clr, cpu_req;
    logic              addr_exec, jtag_req, grant_jtag, grant_cpu;
    cmd_e              pend_cmd;
    logic [31:0]       slot_payload, pend_payload;

    nios2_oci_cmd_slot u_slot (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .jdo                     (jdo),
        .clr                     (slot_clr),
        .slot_valid              (slot_valid),
        .slot_payload            (slot_payload),
        .pend_valid              (pend_valid),
        .pend_cmd                (pend_cmd),
        .pend_payload            (pend_payload),
        .overflow                (overflow)
    );

`ifdef NIOS2_OCIMEM_CPU_PORT_EN
    assign cpu_req         = cpu_read | cpu_write;
    assign cpu_waitrequest = cpu_req & !(state_q == S_CWR | state_q == S_CRD_W);
    assign cpu_readdata    = state_q == S_CRD_W ? mem_rdata : cpu_rdata_q;
    assign mem_addr        = (state_q == S_CWR | state_q == S_CRD) ? cpu_address : jaddr_q;
    assign mem_wdata       = state_q == S_CWR ? cpu_writedata : slot_payload[DATA_W-1:0];
`else
    logic unused_cpu;
    assign unused_cpu      = ^{cpu_read, cpu_write, cpu_address, cpu_writedata, cpu_rdata_q};
    assign cpu_req         = 1'b0;
    assign cpu_waitrequest = 1'b0;
    assign cpu_readdata    = '0;
    assign mem_addr        = jaddr_q;
    assign mem_wdata       = slot_payload[DATA_W-1:0];
`endif

    // RAM strobes decode registered state only, so requests never reach them combinationally
    assign mem_we        = state_q == S_JWR | state_q == S_CWR;
    assign mem_re        = state_q == S_JRD | state_q == S_CRD;
    assign monitor_ready = !slot_valid & !(state_q == S_JWR | state_q == S_JRD | state_q == S_JRD_W);
    assign monitor_error = error_q;
    assign MonDReg       = mon_dreg_q;

    always_comb begin
        state_d     = state_q;
        jaddr_d     = jaddr_q;
        mon_dreg_d  = mon_dreg_q;
        cpu_rdata_d = cpu_rdata_q;
        last_jtag_d = last_jtag_q;
        slot_clr    = 1'b0;
        addr_exec   = state_q == S_IDLE & pend_valid & pend_cmd == CMD_ADDR;
        jtag_req    = pend_valid & pend_cmd != CMD_ADDR;
        grant_jtag  = state_q == S_IDLE & jtag_req & (!cpu_req | !last_jtag_q);
        grant_cpu   = state_q == S_IDLE & cpu_req & !grant_jtag & !addr_exec;
        case (state_q)
            S_IDLE: begin
                if (addr_exec) begin
                    jaddr_d  = pend_payload[ADDR_OFS +: ADDR_W];
                    slot_clr = 1'b1;
                end
                if (grant_jtag) begin
                    state_d     = pend_cmd == CMD_WR ? S_JWR : S_JRD;
                    last_jtag_d = 1'b1;
                end else if (grant_cpu) begin
                    state_d     = cpu_write ? S_CWR : S_CRD;
                    last_jtag_d = 1'b0;
                end
            end
            S_JWR: begin
                jaddr_d  = jaddr_q + ADDR_W'(1);
                slot_clr = 1'b1;
                state_d  = S_IDLE;
            end
            S_JRD:   state_d = S_JRD_W;
            S_JRD_W: begin
                mon_dreg_d = mem_rdata;
                jaddr_d    = jaddr_q + ADDR_W'(1);
                slot_clr   = 1'b1;
                state_d    = S_IDLE;
            end
            S_CRD:   state_d = S_CRD_W;
            S_CRD_W: begin
                cpu_rdata_d = mem_rdata;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // a dropped strobe in the same cycle as an address load keeps the flag set
        error_d = overflow ? 1'b1 : addr_exec ? 1'b0 : error_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            jaddr_q     <= '0;
            mon_dreg_q  <= '0;
            cpu_rdata_q <= '0;
            last_jtag_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            jaddr_q     <= jaddr_d;
            mon_dreg_q  <= mon_dreg_d;
            cpu_rdata_q <= cpu_rdata_d;
            last_jtag_q <= last_jtag_d;
            error_q     <= error_d;
        end
    end
endmodule

// File: tb/tb_nios2_oci_debug_mem_ctrl.sv
// tb_nios2_oci_debug_mem_ctrl: directed bench for the OCI debug memory controller
// with a behavioural single-port RAM (word i preloaded with 0A0B0000+i).
module tb_nios2_oci_debug_mem_ctrl;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
    logic [37:0] jdo;
    logic        cpu_read, cpu_write;
    logic [7:0]  cpu_address;
    logic [31:0] cpu_writedata, cpu_readdata;
    logic        cpu_waitrequest;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata, MonDReg;
    logic        mem_we, mem_re, monitor_ready, monitor_error;

    logic [31:0] ram [256];
    logic        loaded = 1'b0;
    int          strobes = 0;
    int          errors = 0;
    int          checks = 0;
    int          s0, lat, cpu_done;

    nios2_oci_debug_mem_ctrl dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .jdo                     (jdo),
        .cpu_read                (cpu_read),
        .cpu_write               (cpu_write),
        .cpu_address             (cpu_address),
        .cpu_writedata           (cpu_writedata),
        .cpu_readdata            (cpu_readdata),
        .cpu_waitrequest         (cpu_waitrequest),
        .mem_addr                (mem_addr),
        .mem_wdata               (mem_wdata),
        .mem_we                  (mem_we),
        .mem_re                  (mem_re),
        .mem_rdata               (mem_rdata),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 256; i++) ram[i] <= 32'h0A0B0000 + i;
            loaded <= 1'b1;
        end else begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            if (mem_re) mem_rdata <= ram[mem_addr];
        end
    end

    always @(negedge clk) if (mem_we | mem_re) strobes++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [37:0] jdo_addr(input logic [7:0] a);
        return {13'd0, a, 17'd0};
    endfunction

    function automatic logic [37:0] jdo_wr(input logic [31:0] d);
        return {3'd0, d, 3'd0};
    endfunction

    initial begin
        reset_n = 1'b0;
        {take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a} = '0;
        jdo = '0;
        cpu_read = 1'b0; cpu_write = 1'b0; cpu_address = '0; cpu_writedata = '0;
        mem_rdata = '0;
        repeat (3) cyc();
        reset_n = 1'b1;
        #1;
        check("rst_ready", 32'(monitor_ready), 32'd1);
        check("rst_mondreg", MonDReg, 32'd0);
        check("rst_error", 32'(monitor_error), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        s0 = strobes;
        repeat (10) cyc();
        check("rst_idle_strobes", 32'(strobes - s0), 32'd0);

        // address load to top of RAM, write, then read after wrap
        cyc(); take_action_ocimem_a = 1'b1; jdo = jdo_addr(8'hFF);
        cyc(); take_action_ocimem_a = 1'b0; #1;
        check("addr_ff", 32'(mem_addr), 32'hFF);
        cyc(); take_action_ocimem_b = 1'b1; jdo = jdo_wr(32'hDEADBEEF);
        cyc(); take_action_ocimem_b = 1'b0; #1;
        check("wr_we", 32'(mem_we), 32'd1);
        check("wr_addr", 32'(mem_addr), 32'hFF);
        check("wr_data", mem_wdata, 32'hDEADBEEF);
        check("wr_busy", 32'(monitor_ready), 32'd0);
        cyc();
        check("wr_done_ready", 32'(monitor_ready), 32'd1);
        check("wr_done_we", 32'(mem_we), 32'd0);
        check("wrap_addr", 32'(mem_addr), 32'd0);
        check("ram_ff", ram[255], 32'hDEADBEEF);
        cyc(); take_no_action_ocimem_a = 1'b1;
        cyc(); take_no_action_ocimem_a = 1'b0; #1;
        check("rd_re", 32'(mem_re), 32'd1);
        check("rd_addr", 32'(mem_addr), 32'd0);
        check("rd_busy1", 32'(monitor_ready), 32'd0);
        cyc();
        check("rd_re_off", 32'(mem_re), 32'd0);
        check("rd_busy2", 32'(monitor_ready), 32'd0);
        cyc();
        check("rd_ready", 32'(monitor_ready), 32'd1);
        check("rd_mondreg", MonDReg, 32'h0A0B0000);
        check("rd_next_addr", 32'(mem_addr), 32'd1);

        // second strobe while slot is full is dropped
        cyc(); take_action_ocimem_b = 1'b1; jdo = jdo_wr(32'h11111111);
        cyc(); take_action_ocimem_b = 1'b0; take_no_action_ocimem_a = 1'b1; #1;
        check("ovf_we", 32'(mem_we), 32'd1);
        cyc(); take_no_action_ocimem_a = 1'b0; #1;
        check("ovf_error", 32'(monitor_error), 32'd1);
        check("ovf_ready", 32'(monitor_ready), 32'd1);
        check("ovf_no_re", 32'(mem_re), 32'd0);
        cyc();
        check("ovf_no_re2", 32'(mem_re), 32'd0);
        check("ovf_ram1", ram[1], 32'h11111111);
        take_action_ocimem_a = 1'b1; jdo = jdo_addr(8'h10); #1;
        check("ovf_error_held", 32'(monitor_error), 32'd1);
        cyc(); take_action_ocimem_a = 1'b0; #1;
        check("addr_clears_error", 32'(monitor_error), 32'd0);
        check("addr_10", 32'(mem_addr), 32'h10);

        // simultaneous ADDR and WR: ADDR wins, WR dropped
        cyc(); take_action_ocimem_a = 1'b1; take_action_ocimem_b = 1'b1; jdo = jdo_addr(8'h20);
        cyc(); take_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0; #1;
        check("dual_error", 32'(monitor_error), 32'd1);
        check("dual_addr", 32'(mem_addr), 32'h20);
        check("dual_no_we", 32'(mem_we), 32'd0);
        check("dual_ready", 32'(monitor_ready), 32'd1);
        cyc();
        check("dual_no_we2", 32'(mem_we), 32'd0);
        take_action_ocimem_a = 1'b1; jdo = jdo_addr(8'h20);
        cyc(); take_action_ocimem_a = 1'b0; #1;
        check("dual_cleared", 32'(monitor_error), 32'd0);

        // reset asserted while the read waits for RAM data
        cyc(); take_no_action_ocimem_a = 1'b1;
        cyc(); take_no_action_ocimem_a = 1'b0; #1;
        check("rrst_re", 32'(mem_re), 32'd1);
        cyc();
        reset_n = 1'b0; #1;
        check("rrst_mondreg", MonDReg, 32'd0);
        check("rrst_ready", 32'(monitor_ready), 32'd1);
        check("rrst_re_off", 32'(mem_re), 32'd0);
        repeat (2) cyc();
        reset_n = 1'b1;
        s0 = strobes;
        repeat (5) cyc();
        check("rrst_no_strobe", 32'(strobes - s0), 32'd0);
        check("rrst_mondreg2", MonDReg, 32'd0);
        check("rrst_addr", 32'(mem_addr), 32'd0);

`ifdef NIOS2_OCIMEM_CPU_PORT_EN
        cpu_read = 1'b1; cpu_address = 8'd5; #1;
        check("cpu_rd_wait0", 32'(cpu_waitrequest), 32'd1);
        cyc();
        check("cpu_rd_re", 32'(mem_re), 32'd1);
        check("cpu_rd_addr", 32'(mem_addr), 32'd5);
        check("cpu_rd_wait1", 32'(cpu_waitrequest), 32'd1);
        cyc();
        check("cpu_rd_wait2", 32'(cpu_waitrequest), 32'd0);
        check("cpu_rd_data", cpu_readdata, 32'h0A0B0005);
        cyc(); cpu_read = 1'b0;
        cpu_write = 1'b1; cpu_address = 8'd6; cpu_writedata = 32'hA5A5A5A5; #1;
        check("cpu_wr_wait0", 32'(cpu_waitrequest), 32'd1);
        check("cpu_wr_no_we", 32'(mem_we), 32'd0);
        cyc();
        check("cpu_wr_we", 32'(mem_we), 32'd1);
        check("cpu_wr_wait1", 32'(cpu_waitrequest), 32'd0);
        cyc(); cpu_write = 1'b0;
        cyc();
        check("cpu_wr_ram", ram[6], 32'hA5A5A5A5);

        // JTAG reads streaming against a continuous CPU read
        take_action_ocimem_a = 1'b1; jdo = jdo_addr(8'h40);
        cyc(); take_action_ocimem_a = 1'b0;
        cpu_read = 1'b1; cpu_address = 8'd5;
        cpu_done = 0;
        for (int r = 0; r < 3; r++) begin
            take_no_action_ocimem_a = 1'b1;
            lat = 0;
            do begin
                cyc(); take_no_action_ocimem_a = 1'b0; #1;
                lat++;
                if (!cpu_waitrequest) begin
                    cpu_done++;
                    check("stream_cpu_data", cpu_readdata, 32'h0A0B0005);
                end
            end while (!monitor_ready && lat < 10);
            check("stream_latency_ok", 32'(lat <= 6), 32'd1);
            check("stream_mondreg", MonDReg, 32'h0A0B0040 + r);
        end
        check("stream_cpu_served", 32'(cpu_done >= 2), 32'd1);
        cpu_read = 1'b0;
`else
        cpu_read = 1'b1; cpu_write = 1'b1; cpu_address = 8'd5; cpu_writedata = 32'h1;
        s0 = strobes; #1;
        check("nocpu_wait", 32'(cpu_waitrequest), 32'd0);
        check("nocpu_rdata", cpu_readdata, 32'd0);
        repeat (3) cyc();
        check("nocpu_no_strobe", 32'(strobes - s0), 32'd0);
        cpu_read = 1'b0; cpu_write = 1'b0;
`endif
        cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
